instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the pipelined MIPS core. It is the producer for the IF/ID pipeline register and drives its next-sequential-PC and instruction inputs. The block holds the program counter, selects the next PC (sequential, branch or jump), and contains the word-addressed instruction memory. That memory is loaded sequentially by the debug unit. On fetching the HALT word the block stops advancing the PC until reset.

## Interface
Parameters:
- PC_SIZE, 32, program counter width in bits.
- INSTRUCTION_SIZE, 32, instruction word width.
- MEM_DEPTH, 64, instruction memory depth in words; power of two; ADDR_W = log2(MEM_DEPTH).
- HALT_WORD, 32'hFFFF_FFFF, halt instruction encoding.

Ports:
- i_clk  in  1  clock. All state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  pipeline advance enable (debug step/run gate).
- i_stall  in  1  hazard stall. Holds the PC.
- i_pc_src  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 sequential.
- i_branch_pc  in  PC_SIZE  branch target.
- i_jump_pc  in  PC_SIZE  jump/jump-register target.
- i_write_mem  in  1  loader write strobe, one word per cycle.
- i_write_data  in  INSTRUCTION_SIZE  word to load.
- o_pc  out  PC_SIZE  current PC.
- o_next_seq_pc  out  PC_SIZE  o_pc + 4.
- o_instruction  out  INSTRUCTION_SIZE  instruction fetched at o_pc.
- o_halt  out  1  halted state.
- o_mem_empty  out  1  no words loaded.
- o_mem_full  out  1  MEM_DEPTH words loaded.

## Operation
- Registers: pc (PC_SIZE), wr_ptr (ADDR_W+1), state ∈ {RUN, HALTED}, memory array (not reset).
- Fetch (combinational):
  - word address = pc[ADDR_W+1:2]; pc[1:0] ignored.
  - o_instruction = mem[word address] if pc[PC_SIZE-1:ADDR_W+2] == 0 and word address < wr_ptr.
  - Otherwise o_instruction = HALT_WORD (unloaded or out-of-range fetch).
- o_next_seq_pc = pc + 4, modulo 2^PC_SIZE; wraps silently.
- Advance condition: advance = i_enable & ~i_stall & (state == RUN) & (o_instruction != HALT_WORD).
- When advance is true, the next pc is:
  - i_pc_src 00 or 11: o_next_seq_pc.
  - i_pc_src 01: i_branch_pc.
  - i_pc_src 10: i_jump_pc.
- Targets are used unmodified; no alignment check.
- FSM:
  - RUN → HALTED when i_enable & ~i_stall & o_instruction == HALT_WORD. pc holds.
  - HALTED is left only by reset. In HALTED, pc holds regardless of i_enable, i_stall and i_pc_src.
- o_halt = (state == HALTED).
- Loader:
  - When i_write_mem & ~o_mem_full: mem[wr_ptr] <= i_write_data, wr_ptr <= wr_ptr + 1.
  - A write while full is dropped and leaves wr_ptr unchanged.
  - Writes are independent of i_enable, i_stall and state.
- o_mem_empty = (wr_ptr == 0); o_mem_full = (wr_ptr == MEM_DEPTH).

## Timing
- Reset values:
  - o_pc = 0, o_next_seq_pc = 4, o_instruction = HALT_WORD.
  - o_halt = 0, o_mem_empty = 1, o_mem_full = 0.
  - state = RUN.
- o_instruction and o_next_seq_pc are combinational from pc and wr_ptr. They are valid in the same cycle that pc changes.
- pc, state and wr_ptr update one cycle after the qualifying edge inputs. Branch/jump targets take effect at the next edge.
- o_halt rises on the edge that samples HALT_WORD with enable and no stall. o_instruction shows HALT_WORD in the cycle before.
- Simultaneous write to word N and fetch of word N (N == wr_ptr): the fetch returns HALT_WORD in that cycle and the written word from the next cycle. If the same edge also satisfies the RUN → HALTED condition, the halt wins.
- Stall and branch together: the stall wins; pc holds and i_pc_src is ignored.
- Reset asserted mid-run or mid-load:
  - pc, wr_ptr and state clear immediately, without waiting for a clock edge.
  - Memory contents remain, but are unreachable until rewritten, because wr_ptr = 0.

## Test plan
- Reset check: apply reset → o_pc=0, o_next_seq_pc=4, o_instruction=32'hFFFF_FFFF, o_halt=0, o_mem_empty=1, o_mem_full=0.
- Sequential run to halt:
  - Stimulus: load 0x20010005, 0x20020003, 0x00221820, then hold i_enable=1, i_pc_src=00.
  - Response: o_pc steps 0, 4, 8, 12.
  - At pc=12, o_instruction=HALT_WORD; one edge later o_halt=1 and o_pc stays 12 for 10 further cycles.
- Stall:
  - Stimulus: at pc=4, i_stall=1 for 2 cycles.
  - Response: o_pc=4 and o_instruction=0x20020003 for both cycles, then pc=8.
  - Repeat with i_enable=0: same hold behaviour.
- Redirect:
  - Stimulus: at pc=0, i_pc_src=01, i_branch_pc=8.
  - Response: next pc=8.
  - Stimulus: i_pc_src=10, i_jump_pc=4.
  - Response: next pc=4.
  - Stimulus: i_pc_src=01 with i_stall=1.
  - Response: pc unchanged.
- Memory fill:
  - Stimulus: write MEM_DEPTH+1 words with value = index.
  - Response: o_mem_full=1 after word 64. The 65th write is dropped.
  - Response: fetch at pc=252 returns 63; fetch at pc=256 returns HALT_WORD.
- Reset mid-operation:
  - Stimulus: assert reset while o_halt=1 with 3 words loaded.
  - Response: o_pc=0, o_halt=0 and o_mem_empty=1 asynchronously; o_instruction=HALT_WORD until a word is rewritten.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, next-PC select, sequentially loaded
// instruction memory, and a RUN/HALTED state that stops on the HALT word.
module instruction_fetch #(
   parameter int                          PC_SIZE          = 32,
   parameter int                          INSTRUCTION_SIZE = 32,
   parameter int                          MEM_DEPTH        = 64,
   parameter logic [INSTRUCTION_SIZE-1:0] HALT_WORD        = 32'hFFFF_FFFF
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_enable,
   input  logic                        i_stall,
   input  logic [1:0]                  i_pc_src,
   input  logic [PC_SIZE-1:0]          i_branch_pc,
   input  logic [PC_SIZE-1:0]          i_jump_pc,
   input  logic                        i_write_mem,
   input  logic [INSTRUCTION_SIZE-1:0] i_write_data,
   output logic [PC_SIZE-1:0]          o_pc,
   output logic [PC_SIZE-1:0]          o_next_seq_pc,
   output logic [INSTRUCTION_SIZE-1:0] o_instruction,
   output logic                        o_halt,
   output logic                        o_mem_empty,
   output logic                        o_mem_full
);

   localparam int ADDR_W = $clog2(MEM_DEPTH);

   typedef enum logic {RUN, HALTED} state_t;

   state_t                      state, state_next;
   logic [PC_SIZE-1:0]          pc, pc_next;
   logic [ADDR_W:0]             wr_ptr;
   logic [INSTRUCTION_SIZE-1:0] mem [MEM_DEPTH];
   logic [ADDR_W-1:0]           word_addr;
   logic                        in_range;
   logic                        loaded;
   logic                        fetch_halt;
   logic                        write_ok;

   // Unloaded or out-of-range fetches read as HALT so a runaway PC stops the core.
   assign word_addr     = pc[ADDR_W+1:2];
   assign in_range      = (pc[PC_SIZE-1:ADDR_W+2] == '0);
   assign loaded        = ({1'b0, word_addr} < wr_ptr);
   assign o_instruction = (in_range && loaded) ? mem[word_addr] : HALT_WORD;
   assign fetch_halt    = (o_instruction == HALT_WORD);

   assign o_pc          = pc;
   assign o_next_seq_pc = pc + PC_SIZE'(4);
   assign o_halt        = (state == HALTED);
   assign o_mem_empty   = (wr_ptr == '0);
   assign o_mem_full    = (wr_ptr == (ADDR_W+1)'(MEM_DEPTH));
   assign write_ok      = i_write_mem & ~o_mem_full;

   // NOTE: defaults first so every path assigns every output -- no latches.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      if (state == RUN && i_enable && !i_stall) begin
         if (fetch_halt) begin
            state_next = HALTED;
         end else begin
            case (i_pc_src)
               2'b01:   pc_next = i_branch_pc;
               2'b10:   pc_next = i_jump_pc;
               default: pc_next = o_next_seq_pc;
            endcase
         end
      end
   end

   // NOTE: non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= RUN;
         pc     <= '0;
         wr_ptr <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (write_ok) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      end
   end

   // NOTE: memory array is deliberately not reset; wr_ptr gates visibility instead.
   always_ff @(posedge i_clk) begin
      if (write_ok) mem[wr_ptr[ADDR_W-1:0]] <= i_write_data;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: each scenario drives a step table,
// queues the expected post-edge outputs and compares them after the edge.
module tb_instruction_fetch;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] W0   = 32'h2001_0005;
   localparam logic [31:0] W1   = 32'h2002_0003;
   localparam logic [31:0] W2   = 32'h0022_1820;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_enable = 1'b0;
   logic        i_stall = 1'b0;
   logic [1:0]  i_pc_src = 2'b00;
   logic [31:0] i_branch_pc = '0;
   logic [31:0] i_jump_pc = '0;
   logic        i_write_mem = 1'b0;
   logic [31:0] i_write_data = '0;
   logic [31:0] o_pc;
   logic [31:0] o_next_seq_pc;
   logic [31:0] o_instruction;
   logic        o_halt;
   logic        o_mem_empty;
   logic        o_mem_full;

   typedef struct {
      logic        en;
      logic        st;
      logic [1:0]  src;
      logic [31:0] br;
      logic [31:0] jp;
      logic        wr;
      logic [31:0] wd;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        halt;
   } step_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        halt;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   instruction_fetch dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_stall      (i_stall),
      .i_pc_src     (i_pc_src),
      .i_branch_pc  (i_branch_pc),
      .i_jump_pc    (i_jump_pc),
      .i_write_mem  (i_write_mem),
      .i_write_data (i_write_data),
      .o_pc         (o_pc),
      .o_next_seq_pc(o_next_seq_pc),
      .o_instruction(o_instruction),
      .o_halt       (o_halt),
      .o_mem_empty  (o_mem_empty),
      .o_mem_full   (o_mem_full)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic step_t stp(input logic en, input logic st, input logic [1:0] src,
                                 input logic [31:0] br, input logic [31:0] jp,
                                 input logic [31:0] pc, input logic [31:0] ins,
                                 input logic halt);
      step_t s;
      s.en = en; s.st = st; s.src = src; s.br = br; s.jp = jp;
      s.wr = 1'b0; s.wd = '0;
      s.pc = pc; s.ins = ins; s.halt = halt;
      return s;
   endfunction

   task automatic cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_enable = 1'b0; i_stall = 1'b0; i_pc_src = 2'b00;
      i_branch_pc = '0; i_jump_pc = '0; i_write_mem = 1'b0; i_write_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_reset = 1'b1;
      cycle();
      cycle();
      i_reset = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] d);
      i_write_mem = 1'b1;
      i_write_data = d;
      cycle();
      i_write_mem = 1'b0;
   endtask

   task automatic load_program();
      load_word(W0);
      load_word(W1);
      load_word(W2);
   endtask

   // Drives one cycle's inputs and queues the outputs expected after the edge.
   task automatic drive_step(input step_t s);
      i_enable = s.en; i_stall = s.st; i_pc_src = s.src;
      i_branch_pc = s.br; i_jump_pc = s.jp;
      i_write_mem = s.wr; i_write_data = s.wd;
      exp_q.push_back('{pc: s.pc, ins: s.ins, halt: s.halt});
   endtask

   task automatic test_reset();
      exp_t e;
      i_reset = 1'b1;
      idle_inputs();
      #1;
      exp_q.push_back('{pc: 32'd0, ins: HALT, halt: 1'b0});
      e = exp_q.pop_front();
      checks++;
      if (o_pc !== e.pc || o_instruction !== e.ins || o_halt !== e.halt || o_next_seq_pc !== e.pc + 32'd4) begin
         failures++;
         $display("FAIL reset_outputs: pc=%h ins=%h halt=%b nseq=%h, want pc=%h ins=%h halt=%b nseq=%h",
                  o_pc, o_instruction, o_halt, o_next_seq_pc, e.pc, e.ins, e.halt, e.pc + 32'd4);
      end
      checks++;
      if (o_mem_empty !== 1'b1 || o_mem_full !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: empty=%b full=%b, want empty=1 full=0", o_mem_empty, o_mem_full);
      end
      cycle();
      i_reset = 1'b0;
   endtask

   task automatic test_sequential();
      step_t s[14];
      exp_t  e;
      do_reset();
      load_program();
      checks++;
      if (o_mem_empty !== 1'b0 || o_mem_full !== 1'b0) begin
         failures++;
         $display("FAIL seq_flags: empty=%b full=%b, want empty=0 full=0", o_mem_empty, o_mem_full);
      end
      exp_q.push_back('{pc: 32'd0, ins: W0, halt: 1'b0});
      e = exp_q.pop_front();
      checks++;
      if (o_pc !== e.pc || o_instruction !== e.ins || o_halt !== e.halt) begin
         failures++;
         $display("FAIL seq_start: pc=%h ins=%h halt=%b, want pc=%h ins=%h halt=%b",
                  o_pc, o_instruction, o_halt, e.pc, e.ins, e.halt);
      end
      s[0] = stp(1, 0, 2'b00, 0, 0, 32'd4,  W1,   0);
      s[1] = stp(1, 0, 2'b00, 0, 0, 32'd8,  W2,   0);
      s[2] = stp(1, 0, 2'b00, 0, 0, 32'd12, HALT, 0);
      s[3] = stp(1, 0, 2'b00, 0, 0, 32'd12, HALT, 1);
      for (int i = 4; i < 14; i++) s[i] = stp(1, 0, 2'b00, 0, 0, 32'd12, HALT, 1);
      for (int i = 0; i < 14; i++) begin
         drive_step(s[i]);
         cycle();
         e = exp_q.pop_front();
         checks++;
         if (o_pc !== e.pc || o_instruction !== e.ins || o_halt !== e.halt || o_next_seq_pc !== e.pc + 32'd4) begin
            failures++;
            $display("FAIL seq[%0d]: pc=%h ins=%h halt=%b nseq=%h, want pc=%h ins=%h halt=%b nseq=%h",
                     i, o_pc, o_instruction, o_halt, o_next_seq_pc, e.pc, e.ins, e.halt, e.pc + 32'd4);
         end
      end
   endtask

   // Runs right after test_sequential: halted at pc=12 with three words loaded.
   task automatic test_reset_mid();
      exp_t e;
      #2;
      i_reset = 1'b1;
      #1;
      exp_q.push_back('{pc: 32'd0, ins: HALT, halt: 1'b0});
      e = exp_q.pop_front();
      checks++;
      if (o_pc !== e.pc || o_instruction !== e.ins || o_halt !== e.halt || o_mem_empty !== 1'b1) begin
         failures++;
         $display("FAIL reset_async: pc=%h ins=%h halt=%b empty=%b, want pc=%h ins=%h halt=%b empty=1",
                  o_pc, o_instruction, o_halt, o_mem_empty, e.pc, e.ins, e.halt);
      end
      idle_inputs();
      cycle();
      i_reset = 1'b0;
      cycle();
      checks++;
      if (o_instruction !== HALT || o_pc !== 32'd0) begin
         failures++;
         $display("FAIL reset_unreachable: pc=%h ins=%h, want pc=0 ins=%h", o_pc, o_instruction, HALT);
      end
      load_word(32'hABCD_0001);
      checks++;
      if (o_instruction !== 32'hABCD_0001 || o_mem_empty !== 1'b0) begin
         failures++;
         $display("FAIL reset_rewrite: ins=%h empty=%b, want ins=abcd0001 empty=0", o_instruction, o_mem_empty);
      end
   endtask

   task automatic test_stall();
      step_t s[11];
      exp_t  e;
      do_reset();
      load_program();
      s[0]  = stp(1, 0, 2'b00, 0, 0, 32'd4,  W1,   0);
      s[1]  = stp(1, 1, 2'b00, 0, 0, 32'd4,  W1,   0);
      s[2]  = stp(1, 1, 2'b00, 0, 0, 32'd4,  W1,   0);
      s[3]  = stp(1, 0, 2'b00, 0, 0, 32'd8,  W2,   0);
      s[4]  = stp(0, 0, 2'b00, 0, 0, 32'd8,  W2,   0);
      s[5]  = stp(0, 0, 2'b00, 0, 0, 32'd8,  W2,   0);
      s[6]  = stp(1, 0, 2'b00, 0, 0, 32'd12, HALT, 0);
      s[7]  = stp(0, 0, 2'b00, 0, 0, 32'd12, HALT, 0);
      s[8]  = stp(1, 1, 2'b00, 0, 0, 32'd12, HALT, 0);
      s[9]  = stp(1, 0, 2'b00, 0, 0, 32'd12, HALT, 1);
      s[10] = stp(1, 0, 2'b01, 0, 0, 32'd12, HALT, 1);
      for (int i = 0; i < 11; i++) begin
         drive_step(s[i]);
         cycle();
         e = exp_q.pop_front();
         checks++;
         if (o_pc !== e.pc || o_instruction !== e.ins || o_halt !== e.halt || o_next_seq_pc !== e.pc + 32'd4) begin
            failures++;
            $display("FAIL stall[%0d]: pc=%h ins=%h halt=%b nseq=%h, want pc=%h ins=%h halt=%b nseq=%h",
                     i, o_pc, o_instruction, o_halt, o_next_seq_pc, e.pc, e.ins, e.halt, e.pc + 32'd4);
         end
      end
   endtask

   task automatic test_redirect();
      step_t s[8];
      exp_t  e;
      do_reset();
      load_program();
      s[0] = stp(1, 0, 2'b01, 32'd8,  32'd0,   32'd8,   W2,   0);
      s[1] = stp(1, 0, 2'b10, 32'd0,  32'd4,   32'd4,   W1,   0);
      s[2] = stp(1, 1, 2'b01, 32'd8,  32'd0,   32'd4,   W1,   0);
      s[3] = stp(1, 0, 2'b11, 32'd0,  32'd0,   32'd8,   W2,   0);
      s[4] = stp(1, 0, 2'b10, 32'd0,  32'd5,   32'd5,   W1,   0);
      s[5] = stp(1, 0, 2'b01, 32'd0,  32'd12,  32'd0,   W0,   0);
      s[6] = stp(1, 0, 2'b10, 32'd12, 32'd256, 32'd256, HALT, 0);
      s[7] = stp(1, 0, 2'b00, 32'd0,  32'd0,   32'd256, HALT, 1);
      for (int i = 0; i < 8; i++) begin
         drive_step(s[i]);
         cycle();
         e = exp_q.pop_front();
         checks++;
         if (o_pc !== e.pc || o_instruction !== e.ins || o_halt !== e.halt || o_next_seq_pc !== e.pc + 32'd4) begin
            failures++;
            $display("FAIL redirect[%0d]: pc=%h ins=%h halt=%b nseq=%h, want pc=%h ins=%h halt=%b nseq=%h",
                     i, o_pc, o_instruction, o_halt, o_next_seq_pc, e.pc, e.ins, e.halt, e.pc + 32'd4);
         end
      end
   endtask

   // Fetch of the word being written on the same edge that halts: halt wins.
   task automatic test_back_to_back();
      step_t s[3];
      exp_t  e;
      do_reset();
      load_word(W0);
      s[0] = stp(1, 0, 2'b00, 0, 0, 32'd4, HALT, 0);
      s[1] = stp(1, 0, 2'b00, 0, 0, 32'd4, W1,   1);
      s[1].wr = 1'b1;
      s[1].wd = W1;
      s[2] = stp(1, 0, 2'b00, 0, 0, 32'd4, W1,   1);
      for (int i = 0; i < 3; i++) begin
         drive_step(s[i]);
         cycle();
         e = exp_q.pop_front();
         checks++;
         if (o_pc !== e.pc || o_instruction !== e.ins || o_halt !== e.halt || o_next_seq_pc !== e.pc + 32'd4) begin
            failures++;
            $display("FAIL b2b[%0d]: pc=%h ins=%h halt=%b nseq=%h, want pc=%h ins=%h halt=%b nseq=%h",
                     i, o_pc, o_instruction, o_halt, o_next_seq_pc, e.pc, e.ins, e.halt, e.pc + 32'd4);
         end
      end
   endtask

   task automatic test_mem_fill();
      step_t s[4];
      exp_t  e;
      logic  want_full;
      do_reset();
      for (int i = 0; i < 65; i++) begin
         i_write_mem = 1'b1;
         i_write_data = 32'(i);
         cycle();
         want_full = (i >= 63);
         checks++;
         if (o_mem_full !== want_full || o_mem_empty !== 1'b0) begin
            failures++;
            $display("FAIL fill[%0d]: full=%b empty=%b, want full=%b empty=0", i, o_mem_full, o_mem_empty, want_full);
         end
      end
      i_write_mem = 1'b0;
      s[0] = stp(1, 0, 2'b10, 0, 32'd252, 32'd252, 32'd63, 0);
      s[1] = stp(1, 0, 2'b10, 0, 32'd0,   32'd0,   32'd0,  0);
      s[2] = stp(1, 0, 2'b10, 0, 32'd256, 32'd256, HALT,   0);
      s[3] = stp(1, 0, 2'b00, 0, 32'd0,   32'd256, HALT,   1);
      for (int i = 0; i < 4; i++) begin
         drive_step(s[i]);
         cycle();
         e = exp_q.pop_front();
         checks++;
         if (o_pc !== e.pc || o_instruction !== e.ins || o_halt !== e.halt || o_next_seq_pc !== e.pc + 32'd4) begin
            failures++;
            $display("FAIL fill_fetch[%0d]: pc=%h ins=%h halt=%b nseq=%h, want pc=%h ins=%h halt=%b nseq=%h",
                     i, o_pc, o_instruction, o_halt, o_next_seq_pc, e.pc, e.ins, e.halt, e.pc + 32'd4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_reset_mid();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_mem_fill();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
